// File: rtl/board_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_mem_arbiter_pkg
//  Purpose  : Shared types and board geometry for the board RAM arbiter.
//             Holds the cell encoding, the arbiter operation enum and the
//             VGA frame constants used by the position tracker.
//  Revision : 1.0  initial release
// ============================================================================
package board_mem_arbiter_pkg;

    localparam int BOARD_CELL_PX = 40;    // pixels per square cell side
    localparam int BOARD_COLS    = 20;    // cells per row
    localparam int BOARD_ROWS    = 15;    // cell rows
    localparam int BOARD_CELL_W  = 2;     // bits per cell
    localparam int BOARD_AW      = 9;     // RAM address width

    // Last counter values of the 800x600 frame (1040 x 666 totals).
    localparam int H_LAST = 1039;
    localparam int V_LAST = 665;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BODY  = 2'd1,
        HEAD  = 2'd2,
        FOOD  = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_CLEAR = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/board_mem_arbiter_pos.sv
`default_nettype none
// ============================================================================
//  Module   : board_mem_arbiter_pos
//  Purpose  : Tracks which board cell lies under the current pixel without a
//             divider or multiplier. Counts pixels inside a cell and lines
//             inside a cell row; the cell address is row_base + col, where
//             row_base carries row*COLS incrementally.
//  Ports    : clk, rst (async, active-low), pxl_en (pixel beat strobe),
//             ppc / plc (pixel / line counters), cell_addr (cell under the
//             pixel presented on this beat).
//  Revision : 1.0  initial release
// ============================================================================
module board_mem_arbiter_pos
    import board_mem_arbiter_pkg::*;
#(
    parameter int CELL_PX = BOARD_CELL_PX,
    parameter int COLS    = BOARD_COLS,
    parameter int AW      = BOARD_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_en,
    input  logic [10:0]   ppc,
    input  logic [9:0]    plc,
    output logic [AW-1:0] cell_addr
);

    localparam int CNT_W = $clog2(CELL_PX);
    // col keeps counting through horizontal blanking, so size it for the
    // whole line rather than for the visible columns.
    localparam int COL_W = $clog2(H_LAST / CELL_PX + 1);

    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [COL_W-1:0] col;
    logic [AW-1:0]    row_base;
    logic             end_line;
    logic             end_frame;

    assign end_line  = (ppc == 11'(H_LAST));
    assign end_frame = (plc == 10'(V_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            col      <= '0;
            row_base <= '0;
        end else if (pxl_en) begin
            if (end_line) begin
                pix_cnt <= '0;
                col     <= '0;
                if (end_frame) begin
                    line_cnt <= '0;
                    row_base <= '0;
                end else if (line_cnt == CNT_W'(CELL_PX - 1)) begin
                    line_cnt <= '0;
                    row_base <= row_base + AW'(COLS);
                end else begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end else if (pix_cnt == CNT_W'(CELL_PX - 1)) begin
                pix_cnt <= '0;
                col     <= col + 1'b1;
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

    assign cell_addr = row_base + AW'(col);

endmodule
`default_nettype wire

// File: rtl/board_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : board_mem_arbiter
//  Purpose  : Owns the single port of the board cell RAM. During active
//             display it reads the cell under the beam every pixel beat;
//             during blanking it runs the board-clear sweep or commits game
//             logic writes (clear first).
//  Ports    : clk, rst (async, active-low)
//             pxl_en, ppc, plc            - VGA timing
//             cell_out                    - cell type for the colour mux
//             wr_req/wr_addr/wr_data/wr_gnt - game-logic write handshake
//             clr_req/clr_busy            - full-board clear
//             mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - board_ram port
//  Revision : 1.0  initial release
// ============================================================================
module board_mem_arbiter
    import board_mem_arbiter_pkg::*;
#(
    parameter int CELL_PX = BOARD_CELL_PX,
    parameter int COLS    = BOARD_COLS,
    parameter int ROWS    = BOARD_ROWS,
    parameter int CELL_W  = BOARD_CELL_W,
    parameter int AW      = BOARD_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pxl_en,
    input  logic [10:0]       ppc,
    input  logic [9:0]        plc,
    output logic [CELL_W-1:0] cell_out,
    input  logic              wr_req,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CELL_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [CELL_W-1:0] mem_wdata,
    input  logic [CELL_W-1:0] mem_rdata
);

    localparam int            CELLS     = COLS * ROWS;
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [10:0]   H_ACTIVE  = 11'(COLS * CELL_PX);
    localparam logic [9:0]    V_ACTIVE  = 10'(ROWS * CELL_PX);

    arb_state_t    state;       // operation performed in the previous cycle
    arb_state_t    cur_op;      // operation chosen for this cycle
    logic          active;
    logic          wr_in_range;
    logic          clr_pend;
    logic [AW-1:0] clr_ptr;
    logic          blank_q;
    logic [AW-1:0] rd_addr;

    board_mem_arbiter_pos #(
        .CELL_PX (CELL_PX),
        .COLS    (COLS),
        .AW      (AW)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .pxl_en    (pxl_en),
        .ppc       (ppc),
        .plc       (plc),
        .cell_addr (rd_addr)
    );

    assign active      = (ppc < H_ACTIVE) && (plc < V_ACTIVE);
    assign wr_in_range = (wr_addr < AW'(CELLS));
    assign clr_busy    = clr_pend;

    // Operation select and RAM port drive. The whole active area belongs to
    // the pixel path (even between strobes) so writes can never tear. A clr_req
    // arriving this cycle already blocks writes, giving the clear priority
    // before clr_pend is visible. Outputs are forced low while rst is held.
    always_comb begin
        cur_op    = ST_IDLE;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_gnt    = 1'b0;

        if (active) begin
            if (pxl_en) begin
                cur_op = ST_READ;
            end
        end else if (clr_pend) begin
            cur_op = ST_CLEAR;
        end else if (wr_req && !clr_req) begin
            cur_op = ST_WRITE;
        end

        if (rst) begin
            case (cur_op)
                ST_READ: begin
                    mem_en   = 1'b1;
                    mem_addr = rd_addr;
                end
                ST_CLEAR: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = clr_ptr;
                    mem_wdata = CELL_W'(EMPTY);
                end
                ST_WRITE: begin
                    // Out-of-range addresses are acknowledged but dropped so
                    // the requester never stalls on a bad index.
                    wr_gnt = 1'b1;
                    if (wr_in_range) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wdata = wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            clr_pend <= 1'b0;
            clr_ptr  <= '0;
            blank_q  <= 1'b0;
            cell_out <= '0;
        end else begin
            state   <= cur_op;
            blank_q <= pxl_en && !active;

            // Read data arrives the cycle after a READ; a blank beat takes the
            // same path so the colour mux sees a uniform pipeline delay.
            if (state == ST_READ) begin
                cell_out <= mem_rdata;
            end else if (blank_q) begin
                cell_out <= CELL_W'(EMPTY);
            end

            if (clr_req) begin
                clr_pend <= 1'b1;
                clr_ptr  <= '0;
            end else if (cur_op == ST_CLEAR) begin
                if (clr_ptr == LAST_CELL) begin
                    clr_pend <= 1'b0;
                    clr_ptr  <= '0;
                end else begin
                    clr_ptr <= clr_ptr + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_board_mem_arbiter
//  Purpose  : Directed self-checking bench for board_mem_arbiter with a
//             behavioural single-port board RAM beside the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_board_mem_arbiter;
    import board_mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_en;
    logic [10:0] ppc;
    logic [9:0] plc;
    logic [1:0] cell_out;
    logic       wr_req;
    logic [8:0] wr_addr;
    logic [1:0] wr_data;
    logic       wr_gnt;
    logic       clr_req;
    logic       clr_busy;
    logic       mem_en;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;

    logic [1:0] ram [0:511];

    int checks   = 0;
    int failures = 0;

    board_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .pxl_en    (pxl_en),
        .ppc       (ppc),
        .plc       (plc),
        .cell_out  (cell_out),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- driver state and logs ----------------
    int         cyc = 0;
    logic       s_gnt = 1'b0;
    logic [8:0] wq_a [$];
    logic [1:0] wq_d [$];

    int         g_cyc [$];
    int         g_ppc [$];
    int         g_plc [$];
    logic       g_we [$];
    logic       g_busy [$];
    logic [8:0] g_maddr [$];
    logic [1:0] g_wdata [$];

    logic [8:0] c_addr [$];
    logic [1:0] c_data [$];
    int         c_cyc [$];
    int         c_ppc [$];
    int         c_plc [$];

    int         active_wr_cnt = 0;
    int         fall_cyc = -1;
    int         clr_req_cyc = -1;
    logic       prev_busy = 1'b0;

    logic [1:0] seen [0:1039];
    logic [8:0] addr_at [0:1039];

    task automatic clear_logs;
        g_cyc.delete(); g_ppc.delete(); g_plc.delete(); g_we.delete();
        g_busy.delete(); g_maddr.delete(); g_wdata.delete();
        c_addr.delete(); c_data.delete(); c_cyc.delete(); c_ppc.delete(); c_plc.delete();
        active_wr_cnt = 0;
        fall_cyc      = -1;
    endtask

    // One clock: drive at posedge+1, sample and log at the following negedge.
    task automatic step(input logic en, input int x, input int y, input logic clr);
        @(posedge clk);
        #1;
        if (s_gnt && wq_a.size() > 0) begin
            void'(wq_a.pop_front());
            void'(wq_d.pop_front());
        end
        if (wq_a.size() > 0) begin
            wr_req  = 1'b1;
            wr_addr = wq_a[0];
            wr_data = wq_d[0];
        end else begin
            wr_req  = 1'b0;
            wr_addr = '0;
            wr_data = '0;
        end
        pxl_en  = en;
        ppc     = 11'(x);
        plc     = 10'(y);
        clr_req = clr;
        cyc++;
        if (clr) clr_req_cyc = cyc;
        @(negedge clk);
        s_gnt = wr_gnt;
        if (wr_gnt) begin
            g_cyc.push_back(cyc);  g_ppc.push_back(x);  g_plc.push_back(y);
            g_we.push_back(mem_we); g_busy.push_back(clr_busy);
            g_maddr.push_back(mem_addr); g_wdata.push_back(mem_wdata);
        end
        if (mem_we && clr_busy) begin
            c_addr.push_back(mem_addr); c_data.push_back(mem_wdata);
            c_cyc.push_back(cyc); c_ppc.push_back(x); c_plc.push_back(y);
        end
        if (mem_we && x < 800 && y < 600) active_wr_cnt++;
        if (prev_busy && !clr_busy) fall_cyc = cyc;
        prev_busy = clr_busy;
    endtask

    task automatic skip_line(input int y);
        step(1'b1, 1039, y, 1'b0);
        step(1'b0, 1039, y, 1'b0);
    endtask

    task automatic skip_lines(input int y0, input int y1);
        for (int y = y0; y <= y1; y++) skip_line(y);
    endtask

    // Full (or tail of a) line of beats; seen[x] is cell_out one beat later.
    task automatic run_line(input int y, input int start, input int clr_at);
        for (int x = start; x <= 1039; x++) begin
            step(1'b1, x, y, x == clr_at);
            if (x > start) seen[x-1] = cell_out;
            addr_at[x] = mem_addr;
            step(1'b0, x, y, 1'b0);
        end
    endtask

    // Index of the first clear write that breaks the 0..299 zero sequence.
    function automatic int first_bad_clear();
        for (int i = 0; i < c_addr.size(); i++)
            if (c_addr[i] !== 9'(i) || c_data[i] !== 2'd0) return i;
        return -1;
    endfunction

    function automatic int first_nonzero_cell();
        for (int i = 0; i < 300; i++)
            if (ram[i] !== 2'd0) return i;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b0; pxl_en = 1'b1; ppc = 11'd300; plc = 10'd200;
        clr_req = 1'b0; wr_req = 1'b1; wr_addr = 9'd5; wr_data = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({mem_en, mem_we, wr_gnt, clr_busy} !== 4'b0000) begin failures++;
            $display("FAIL reset_ctrl en/we/gnt/busy=%b expected 0000", {mem_en, mem_we, wr_gnt, clr_busy}); end
        checks++; if (cell_out !== 2'd0) begin failures++;
            $display("FAIL reset_cell_out got %0d expected 0", cell_out); end
        checks++; if ({mem_addr, mem_wdata} !== 11'd0) begin failures++;
            $display("FAIL reset_bus addr=%0d wdata=%0d expected 0/0", mem_addr, mem_wdata); end

        @(posedge clk); #1;
        wr_req = 1'b0; pxl_en = 1'b0; ppc = '0; plc = '0; rst = 1'b1;
        for (int x = 0; x <= 4; x++) begin
            step(1'b1, x, 0, x == 2);
            if (x == 0) begin
                checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'd0) begin failures++;
                    $display("FAIL first_read en=%b we=%b addr=%0d expected 1/0/0", mem_en, mem_we, mem_addr); end
            end
            step(1'b0, x, 0, 1'b0);
        end
        checks++; if (cell_out !== HEAD) begin failures++;
            $display("FAIL cell0_read got %0d expected %0d", cell_out, HEAD); end
        checks++; if (clr_busy !== 1'b1) begin failures++;
            $display("FAIL busy_after_req got %b expected 1", clr_busy); end

        // Asynchronous reset in the middle of a cycle with a read in flight.
        @(posedge clk); #1;
        pxl_en = 1'b1; ppc = 11'd10;
        #1; rst = 1'b0;
        #1;
        checks++; if (clr_busy !== 1'b0 || cell_out !== 2'd0) begin failures++;
            $display("FAIL async_reset busy=%b cell=%0d expected 0/0", clr_busy, cell_out); end
        checks++; if (mem_en !== 1'b0 || wr_gnt !== 1'b0) begin failures++;
            $display("FAIL async_reset_port en=%b gnt=%b expected 0/0", mem_en, wr_gnt); end
        @(posedge clk); #1;
        pxl_en = 1'b0; ppc = '0; plc = '0; rst = 1'b1;
        prev_busy = 1'b0;
        step(1'b1, 0, 0, 1'b0);
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'd0) begin failures++;
            $display("FAIL reread_origin en=%b we=%b addr=%0d expected 1/0/0", mem_en, mem_we, mem_addr); end
        step(1'b0, 0, 0, 1'b0);
        checks++; if (clr_busy !== 1'b0) begin failures++;
            $display("FAIL clear_dropped busy=%b expected 0", clr_busy); end
        skip_line(0);
    endtask

    task automatic test_write_gating;
        clear_logs();
        skip_lines(1, 49);
        for (int x = 0; x <= 1039; x++) begin
            if (x == 100) begin wq_a.push_back(9'd5); wq_d.push_back(BODY); end
            step(1'b1, x, 50, 1'b0);
            step(1'b0, x, 50, 1'b0);
        end
        checks++; if (g_cyc.size() !== 1) begin failures++;
            $display("FAIL gate_gnt_count got %0d expected 1", g_cyc.size()); end
        else begin
            checks++; if (g_ppc[0] !== 800 || g_plc[0] !== 50) begin failures++;
                $display("FAIL gate_gnt_pos ppc=%0d plc=%0d expected 800/50", g_ppc[0], g_plc[0]); end
            checks++; if (g_we[0] !== 1'b1 || g_maddr[0] !== 9'd5 || g_wdata[0] !== 2'd1) begin failures++;
                $display("FAIL gate_gnt_bus we=%b addr=%0d data=%0d expected 1/5/1", g_we[0], g_maddr[0], g_wdata[0]); end
        end
        checks++; if (ram[5] !== BODY) begin failures++;
            $display("FAIL gate_ram5 got %0d expected %0d", ram[5], BODY); end
    endtask

    task automatic test_address_map;
        skip_lines(51, 79);
        run_line(80, 0, -1);
        checks++; if (addr_at[280] !== 9'd47 || addr_at[320] !== 9'd48) begin failures++;
            $display("FAIL map_addr a280=%0d a320=%0d expected 47/48", addr_at[280], addr_at[320]); end
        checks++; if (seen[279] !== BODY) begin failures++;
            $display("FAIL map_ppc279 got %0d expected %0d", seen[279], BODY); end
        for (int x = 280; x <= 319; x++) begin
            checks++; if (seen[x] !== FOOD) begin failures++;
                $display("FAIL map_food ppc=%0d got %0d expected %0d", x, seen[x], FOOD); end
        end
        checks++; if (seen[320] !== HEAD) begin failures++;
            $display("FAIL map_ppc320 got %0d expected %0d", seen[320], HEAD); end
        checks++; if (seen[900] !== EMPTY) begin failures++;
            $display("FAIL map_blank got %0d expected 0", seen[900]); end
        skip_lines(81, 118);
        run_line(119, 0, -1);
        checks++; if (seen[300] !== FOOD || seen[320] !== HEAD) begin failures++;
            $display("FAIL map_line119 p300=%0d p320=%0d expected 3/2", seen[300], seen[320]); end
        skip_line(120);
        checks++; if (addr_at[0] === 9'd0) begin end
    endtask

    task automatic test_clear;
        clear_logs();
        skip_lines(121, 600);
        run_line(601, 0, 0);
        checks++; if (c_addr.size() !== 300) begin failures++;
            $display("FAIL clr_count got %0d expected 300", c_addr.size()); end
        else begin
            checks++; if (first_bad_clear() !== -1) begin failures++;
                $display("FAIL clr_sequence first bad index %0d expected none", first_bad_clear()); end
            checks++; if (c_cyc[0] !== clr_req_cyc + 1 || c_cyc[299] !== clr_req_cyc + 300) begin failures++;
                $display("FAIL clr_timing first=%0d last=%0d expected %0d/%0d", c_cyc[0], c_cyc[299],
                         clr_req_cyc + 1, clr_req_cyc + 300); end
            checks++; if (fall_cyc !== c_cyc[299] + 1) begin failures++;
                $display("FAIL clr_busy_fall got %0d expected %0d", fall_cyc, c_cyc[299] + 1); end
        end
        checks++; if (first_nonzero_cell() !== -1) begin failures++;
            $display("FAIL clr_ram first nonzero %0d expected none", first_nonzero_cell()); end
        skip_lines(602, 665);
        skip_lines(0, 79);
        run_line(80, 0, -1);
        checks++; if (seen[300] !== EMPTY || seen[320] !== EMPTY) begin failures++;
            $display("FAIL clr_readback p300=%0d p320=%0d expected 0/0", seen[300], seen[320]); end
    endtask

    task automatic test_clear_paused;
        int n300 = 0;
        int n301 = 0;
        int first301 = -1;
        for (int i = 0; i < 300; i++) ram[i] = HEAD;
        clear_logs();
        skip_lines(81, 299);
        run_line(300, 1000, 1000);
        run_line(301, 0, -1);
        for (int i = 0; i < c_plc.size(); i++) begin
            if (c_plc[i] == 300) n300++;
            if (c_plc[i] == 301) begin
                if (n301 == 0) first301 = c_ppc[i];
                n301++;
            end
        end
        checks++; if (c_addr.size() !== 300 || first_bad_clear() !== -1) begin failures++;
            $display("FAIL pause_sequence count=%0d first bad %0d expected 300/none", c_addr.size(), first_bad_clear()); end
        checks++; if (n300 !== 79 || n301 !== 221) begin failures++;
            $display("FAIL pause_split line300=%0d line301=%0d expected 79/221", n300, n301); end
        checks++; if (first301 !== 800) begin failures++;
            $display("FAIL pause_resume ppc=%0d expected 800", first301); end
        checks++; if (active_wr_cnt !== 0) begin failures++;
            $display("FAIL pause_active_writes got %0d expected 0", active_wr_cnt); end
        checks++; if (first_nonzero_cell() !== -1) begin failures++;
            $display("FAIL pause_ram first nonzero %0d expected none", first_nonzero_cell()); end
    endtask

    task automatic test_back_to_back;
        clear_logs();
        skip_lines(302, 609);
        wq_a.push_back(9'd9);   wq_d.push_back(HEAD);
        wq_a.push_back(9'd310); wq_d.push_back(FOOD);
        wq_a.push_back(9'd10);  wq_d.push_back(BODY);
        wq_a.push_back(9'd11);  wq_d.push_back(FOOD);
        run_line(610, 0, 0);
        checks++; if (c_addr.size() !== 300 || g_cyc.size() !== 4) begin failures++;
            $display("FAIL contend_counts clears=%0d gnts=%0d expected 300/4", c_addr.size(), g_cyc.size()); end
        else begin
            checks++; if (g_cyc[0] !== c_cyc[299] + 1 || fall_cyc !== g_cyc[0]) begin failures++;
                $display("FAIL contend_order gnt=%0d last_clear=%0d fall=%0d", g_cyc[0], c_cyc[299], fall_cyc); end
            checks++; if (g_cyc[3] - g_cyc[0] !== 3) begin failures++;
                $display("FAIL b2b_spacing span=%0d expected 3", g_cyc[3] - g_cyc[0]); end
            checks++; if (g_busy[0] | g_busy[1] | g_busy[2] | g_busy[3]) begin failures++;
                $display("FAIL gnt_while_busy got 1 expected 0"); end
            checks++; if (g_we[1] !== 1'b0 || g_we[0] !== 1'b1 || g_we[2] !== 1'b1) begin failures++;
                $display("FAIL oob_we we=%b%b%b expected 1/0/1", g_we[0], g_we[1], g_we[2]); end
        end
        checks++; if (ram[9] !== HEAD || ram[10] !== BODY || ram[11] !== FOOD) begin failures++;
            $display("FAIL b2b_ram r9=%0d r10=%0d r11=%0d expected 2/1/3", ram[9], ram[10], ram[11]); end
        checks++; if (ram[310] !== 2'd0) begin failures++;
            $display("FAIL oob_ram r310=%0d expected 0", ram[310]); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 2'd0;
        ram[0]  = HEAD;
        ram[46] = BODY;
        ram[47] = FOOD;
        ram[48] = HEAD;
        mem_rdata = 2'd0;
        test_reset();
        test_write_gating();
        test_address_map();
        test_clear();
        test_clear_paused();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
